// File: rtl/wb_pkg.sv
// ============================================================================
// Module : wb_pkg
// Brief  : Shared widths, source indices and arbitration modes for write-back.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam int DEF_NUM_SRC = 6;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_CODE_W  = 8;
    localparam int DEF_DEPTH   = 2;

    typedef enum logic [2:0] {
        SRC_ALU   = 3'd0,
        SRC_STACK = 3'd1,
        SRC_UART  = 3'd2,
        SRC_SCHED = 3'd3,
        SRC_JMP   = 3'd4,
        SRC_DMA   = 3'd5
    } wb_src_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Next round-robin start position after a grant to idx.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_src_fifo.sv
// ============================================================================
// Module : wb_src_fifo
// Brief  : Per-source write-back queue; ready reflects occupancy before pop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_src_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_ready,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_count < CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && o_ready;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read once its count covers it.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/write_back_arbiter.sv
// ============================================================================
// Module : write_back_arbiter
// Brief  : Queues writes from NUM_SRC sources and emits one per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module write_back_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CODE_W  = DEF_CODE_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int RR_MODE = ARB_FIXED
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*CODE_W-1:0]  src_code,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic                       REG_write_back_flag,
    output logic [CODE_W-1:0]          REG_write_back_code,
    output logic [DATA_W-1:0]          REG_write_back_data,
    output logic                       idle
);

    localparam int ENT_W = DATA_W + CODE_W;
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] w_empty;
    logic [NUM_SRC-1:0] w_pop;
    logic [ENT_W-1:0]   w_head [NUM_SRC];
    logic               w_grant_vld;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [PTR_W-1:0]   w_scan_idx;
    int                 w_start;
    logic [PTR_W-1:0]   r_ptr;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            wb_src_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (ENT_W)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_flush (flush),
                .i_push  (src_valid[i]),
                .i_data  ({src_code[i*CODE_W +: CODE_W], src_data[i*DATA_W +: DATA_W]}),
                .i_pop   (w_pop[i]),
                .o_data  (w_head[i]),
                .o_ready (src_ready[i]),
                .o_empty (w_empty[i])
            );
        end
    endgenerate

    // Scan from the round-robin pointer (or from 0) and take the first non-empty head.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        w_start     = (RR_MODE == ARB_RR) ? int'(r_ptr) : 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_scan_idx = PTR_W'((w_start + k) % NUM_SRC);
            if (!w_grant_vld && !w_empty[w_scan_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
    end

    assign w_pop = (w_grant_vld && !flush) ? (NUM_SRC'(1) << w_grant_idx) : '0;
    assign idle  = (&w_empty) && !REG_write_back_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            REG_write_back_flag <= 1'b0;
            REG_write_back_code <= '0;
            REG_write_back_data <= '0;
            r_ptr               <= '0;
        end else if (flush) begin
            REG_write_back_flag <= 1'b0;
            r_ptr               <= '0;
        end else if (w_grant_vld) begin
            REG_write_back_flag <= 1'b1;
            REG_write_back_code <= w_head[w_grant_idx][ENT_W-1 -: CODE_W];
            REG_write_back_data <= w_head[w_grant_idx][DATA_W-1:0];
            r_ptr               <= PTR_W'(wrap_inc(int'(w_grant_idx), NUM_SRC));
        end else begin
            REG_write_back_flag <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_write_back_arbiter.sv
// ============================================================================
// Module : tb_write_back_arbiter
// Brief  : Drives a fixed-priority and a round-robin instance with one stimulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_write_back_arbiter;

    localparam int NS = 6;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int DP = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [NS-1:0]   src_valid = '0;
    logic [NS*CW-1:0] src_code = '0;
    logic [NS*DW-1:0] src_data = '0;

    logic [NS-1:0]   ready_o [2];
    logic            flag_o  [2];
    logic [CW-1:0]   code_o  [2];
    logic [DW-1:0]   data_o  [2];
    logic            idle_o  [2];

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: one queue per (mode, source), expected output registers.
    logic [CW+DW-1:0] mq [2*NS][$];
    logic             e_flag [2];
    logic [CW-1:0]    e_code [2];
    logic [DW-1:0]    e_data [2];
    int               e_ptr  [2];

    always #5 clk = ~clk;

    write_back_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .CODE_W(CW), .DEPTH(DP), .RR_MODE(0)) u_fp (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .src_valid (src_valid), .src_code (src_code), .src_data (src_data),
        .src_ready (ready_o[0]), .REG_write_back_flag (flag_o[0]),
        .REG_write_back_code (code_o[0]), .REG_write_back_data (data_o[0]), .idle (idle_o[0])
    );

    write_back_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .CODE_W(CW), .DEPTH(DP), .RR_MODE(1)) u_rr (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .src_valid (src_valid), .src_code (src_code), .src_data (src_data),
        .src_ready (ready_o[1]), .REG_write_back_flag (flag_o[1]),
        .REG_write_back_code (code_o[1]), .REG_write_back_data (data_o[1]), .idle (idle_o[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < 2*NS; q++) mq[q].delete();
        for (int m = 0; m < 2; m++) begin
            e_flag[m] = 1'b0; e_code[m] = '0; e_data[m] = '0; e_ptr[m] = 0;
        end
    endtask

    function automatic logic model_idle(input int m);
        for (int s = 0; s < NS; s++) if (mq[m*NS+s].size() != 0) return 1'b0;
        return !e_flag[m];
    endfunction

    task automatic check_outputs(input string tag);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s_flag_m%0d", tag, m), 64'(flag_o[m]), 64'(e_flag[m]));
            check($sformatf("%s_code_m%0d", tag, m), 64'(code_o[m]), 64'(e_code[m]));
            check($sformatf("%s_data_m%0d", tag, m), 64'(data_o[m]), 64'(e_data[m]));
            check($sformatf("%s_idle_m%0d", tag, m), 64'(idle_o[m]), 64'(model_idle(m)));
        end
    endtask

    // One clock: check readiness, advance the reference, then compare after the edge.
    task automatic cycle(input string tag);
        logic [NS-1:0] rdy;
        int g;
        int s;
        logic [CW+DW-1:0] ent;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NS; i++) rdy[i] = (mq[m*NS+i].size() < DP);
            check($sformatf("%s_ready_m%0d", tag, m), 64'(ready_o[m]), 64'(rdy));
            if (flush) begin
                for (int i = 0; i < NS; i++) mq[m*NS+i].delete();
                e_flag[m] = 1'b0;
                e_ptr[m]  = 0;
            end else begin
                g = -1;
                for (int k = 0; k < NS; k++) begin
                    s = (m == 1) ? (e_ptr[m] + k) % NS : k;
                    if (g < 0 && mq[m*NS+s].size() > 0) g = s;
                end
                if (g >= 0) begin
                    ent       = mq[m*NS+g].pop_front();
                    e_flag[m] = 1'b1;
                    e_code[m] = ent[CW+DW-1:DW];
                    e_data[m] = ent[DW-1:0];
                    e_ptr[m]  = (g + 1) % NS;
                end else begin
                    e_flag[m] = 1'b0;
                end
                for (int i = 0; i < NS; i++)
                    if (src_valid[i] && rdy[i])
                        mq[m*NS+i].push_back({src_code[i*CW +: CW], src_data[i*DW +: DW]});
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic set_src(input int s, input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        src_valid[s]          = v;
        src_code[s*CW +: CW]  = c;
        src_data[s*DW +: DW]  = d;
    endtask

    task automatic check_reset_state(input string tag);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s_flag_m%0d", tag, m), 64'(flag_o[m]), 64'd0);
            check($sformatf("%s_code_m%0d", tag, m), 64'(code_o[m]), 64'd0);
            check($sformatf("%s_data_m%0d", tag, m), 64'(data_o[m]), 64'd0);
            check($sformatf("%s_ready_m%0d", tag, m), 64'(ready_o[m]), 64'h3f);
            check($sformatf("%s_idle_m%0d", tag, m), 64'(idle_o[m]), 64'd1);
        end
    endtask

    initial begin
        logic [CW-1:0] grants [$];
        logic [DW-1:0] stack_val;
        int            stack_sent;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single ALU write accepted on the first edge after release.
        set_src(0, 1'b1, 8'h05, 32'h0000_00AA);
        cycle("single_push");
        src_valid = '0;
        cycle("single_out");
        check("single_flag", 64'(flag_o[0]), 64'd1);
        check("single_code", 64'(code_o[0]), 64'h05);
        check("single_data", 64'(data_o[0]), 64'hAA);
        cycle("single_after");
        check("single_done_flag", 64'(flag_o[0]), 64'd0);
        check("single_done_idle", 64'(idle_o[0]), 64'd1);

        // Fixed-priority collision between ALU and DMA.
        set_src(0, 1'b1, 8'h01, 32'h1111_0001);
        set_src(5, 1'b1, 8'h02, 32'h5555_0002);
        cycle("coll_push");
        src_valid = '0;
        cycle("coll_first");
        check("coll_first_code", 64'(code_o[0]), 64'h01);
        cycle("coll_second");
        check("coll_second_code", 64'(code_o[0]), 64'h02);
        check("coll_second_flag", 64'(flag_o[0]), 64'd1);
        repeat (2) cycle("coll_drain");

        // Round-robin fairness: pointer cleared by flush, then all sources stay valid.
        flush = 1'b1;
        cycle("rr_flush");
        flush = 1'b0;
        for (int s = 0; s < NS; s++) set_src(s, 1'b1, CW'(s), DW'(32'hC0DE_0000 + s));
        for (int c = 0; c < 14; c++) begin
            cycle("rr_fair");
            if (flag_o[1]) grants.push_back(code_o[1]);
        end
        check("rr_grant_count_ge7", 64'(grants.size() >= 7), 64'd1);
        for (int i = 0; i < 7; i++)
            if (i < grants.size())
                check($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(i % NS));
        src_valid = '0;
        repeat (14) cycle("rr_drain");

        // STACK pushes three writes while ALU saturates the fixed-priority arbiter.
        set_src(0, 1'b1, 8'hA0, 32'hAAAA_0000);
        stack_sent = 0;
        stack_val  = 32'h5700_0001;
        set_src(1, 1'b1, 8'h10, stack_val);
        for (int c = 0; c < 12 && stack_sent < 3; c++) begin
            logic acc;
            acc = (mq[1].size() < DP);
            cycle("full");
            if (acc) begin
                stack_sent++;
                stack_val = stack_val + 1;
                set_src(1, stack_sent < 3, 8'h10 + 8'(stack_sent), stack_val);
            end
            if (stack_sent == 2) check("full_stack_ready_low", 64'(ready_o[0][1]), 64'd0);
        end
        check("full_stack_sent", 64'(stack_sent), 64'd2);
        src_valid[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            logic acc;
            acc = (mq[1].size() < DP);
            cycle("full_release");
            if (acc && src_valid[1]) begin
                stack_sent++;
                src_valid[1] = 1'b0;
            end
        end
        check("full_stack_sent_all", 64'(stack_sent), 64'd3);

        // Four writes queued, then flush.
        for (int s = 0; s < 4; s++) set_src(s, 1'b1, CW'(8'h40 + s), DW'(32'hF1F1_0000 + s));
        cycle("flush_fill");
        src_valid = '0;
        flush = 1'b1;
        cycle("flush_pulse");
        flush = 1'b0;
        check("flush_ready_fp", 64'(ready_o[0]), 64'h3f);
        check("flush_flag_rr", 64'(flag_o[1]), 64'd0);
        repeat (3) cycle("flush_after");

        // Async reset dropped mid-burst.
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < NS; s++) set_src(s, 1'($urandom_range(0, 1)), CW'($urandom), DW'($urandom));
            cycle("burst");
        end
        #2;
        rst_n = 1'b0;
        src_valid = '0;
        #1;
        model_reset();
        check_reset_state("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_src(3, 1'b1, 8'h33, 32'hDEAD_BEEF);
        cycle("post_rst_push");
        src_valid = '0;
        cycle("post_rst_out");
        check("post_rst_code", 64'(code_o[1]), 64'h33);
        check("post_rst_data", 64'(data_o[1]), 64'hDEAD_BEEF);

        // Randomized traffic, including code 0 and occasional flush.
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < NS; s++)
                set_src(s, 1'($urandom_range(0, 2) != 0),
                        ($urandom_range(0, 7) == 0) ? 8'h00 : CW'($urandom), DW'($urandom));
            flush = ($urandom_range(0, 31) == 0);
            cycle("rand");
        end
        flush = 1'b0;
        src_valid = '0;
        repeat (16) cycle("final_drain");
        check("final_idle_fp", 64'(idle_o[0]), 64'd1);
        check("final_idle_rr", 64'(idle_o[1]), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
